bitmap_alloc_ctrl: RTL and testbench
====================================

// Module: bitmap_alloc_ctrl
// PURPOSE
//  Slot allocator that sits upstream of ram_3port_dp and owns its write port and both read ports.
//  The RAM holds a bitmap of DEPTH*DATA_WIDTH slots; bit=1 means allocated.
//  Serves alloc (find lowest free bit and set it) and free (clear bit) requests over valid/ready.
//  Scans two words per cycle using read ports 1 and 2.
// PARAMETERS
//  ADDR_WIDTH  6   bitmap word address width; DEPTH = 2**ADDR_WIDTH words; must be >= 1
//  DATA_WIDTH  64  bits per word, power of 2; BIT_W = log2(DATA_WIDTH); IDX_W = ADDR_WIDTH + BIT_W
// PORTS
//  clk             in   1           clock; everything on rising edge
//  rst_n           in   1           synchronous active-low reset
//  req_valid       in   1           request valid
//  req_ready       out  1           request accepted when valid&ready
//  req_op          in   1           0 = alloc, 1 = free
//  req_index       in   IDX_W       slot to free, {word, bit}; ignored for alloc
//  rsp_valid       out  1           response valid; held until rsp_ready
//  rsp_ready       in   1           response consumed when valid&ready
//  rsp_ok          out  1           1 = success; 0 = alloc found no free slot, or free hit a bit that was already 0
//  rsp_index       out  IDX_W       allocated slot (alloc); echo of req_index (free)
//  ram_write_en    out  1           to ram write_en
//  ram_write_addr  out  ADDR_WIDTH  to ram write_addr
//  ram_write_data  out  DATA_WIDTH  to ram write_data
//  ram_read_addr1  out  ADDR_WIDTH  to ram read_addr1
//  ram_read_data1  in   DATA_WIDTH  from ram; valid the cycle after ram_read_addr1 is sampled
//  ram_read_addr2  out  ADDR_WIDTH  to ram read_addr2
//  ram_read_data2  in   DATA_WIDTH  from ram; 1-cycle latency, same as port 1
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_ok=0, rsp_index=0, ram_write_en=0, all addrs=0.
//    hint=0; state=INIT, init_ptr=0.
//  INIT
//    - ram_write_en=1, addr=init_ptr, data=0, for DEPTH consecutive cycles (0..DEPTH-1).
//    - Then IDLE; req_ready is 1 from the following cycle.
//  IDLE
//    - req_ready=1 only here, and only while rsp_valid=0 (one request outstanding).
//    - On accept, latch op and index, then go to RD.
//  RD
//    - free: read_addr1 = req word.
//    - alloc: read_addr1 = ptr, read_addr2 = ptr+1 mod DEPTH; ptr=hint, scanned=0.
//  CHK (read data valid)
//    - free, bit=1: write word with bit cleared, ok=1.
//    - free, bit=0: no write, ok=0.
//    - alloc, word1 != all-ones: set lowest 0 bit in word1; write at ptr; index={ptr,bit}; hint=ptr; ok=1.
//    - alloc, else word2 != all-ones: same for word2 at ptr+1; hint=ptr+1.
//    - alloc, else: ptr+=2 (wrap), scanned+=2.
//        scanned>=DEPTH: ok=0, index=0, no write.
//        else issue reads ptr, ptr+1 in this same cycle and stay in CHK (no write that cycle).
//    - Any resolution goes to RSP.
//  RSP
//    - rsp_valid=1; ok and index stable until rsp_ready; then IDLE.
//  Latency
//    - Free, or alloc hit in first pair: rsp_valid 3 cycles after the accept edge.
//    - Each extra word pair adds 1 cycle.
//    - Worst-case fail: 2 + DEPTH/2 cycles.
//  Edge cases
//    - DEPTH=2: the single pair covers all words.
//    - Writes occur only in CHK; the next read is >=2 cycles later, so there is no RAW hazard.
//    - Free does not move hint.
//    - rst_n low in any state: outputs take reset values the next edge and INIT re-runs.
//      All allocations are lost; a pending rsp is dropped.
// CONFIGURATION
//  BMA_USED_CNT_EN defined:
//    - Adds output used_cnt [IDX_W:0]; reset 0, cleared in INIT.
//    - +1 on successful alloc, -1 on successful free, updated at the CHK edge.
//    - Alloc accepted while used_cnt == DEPTH*DATA_WIDTH: skip RD/CHK, go straight to RSP.
//      rsp_valid the cycle after accept, ok=0, index=0.
//  Undefined: no used_cnt port; a full bitmap is detected only by the full scan.
// TESTING
//  1 Init: rst_n=0 for 2 cycles, then 1.
//    -> write_en=1 for 64 cycles, addr 0..63, data 0; req_ready=1 on cycle 65.
//  2 Three allocs.
//    -> rsp_index 0,1,2, all ok=1; word 0 writes 0x1, 0x3, 0x7; hint=0.
//  3 Free idx 1, then alloc.
//    -> free ok=1, write word0=0x5; alloc returns idx 1, ok=1, word0=0x7.
//  4 Free idx 5 (bit already 0) -> ok=0, ram_write_en stays 0 through RSP.
//  5 4096 allocs -> all ok=1, indices 0..4095 in order.
//    4097th -> ok=0, with 32 CHK cycles.
//    With BMA_USED_CNT_EN -> ok=0 one cycle after accept, used_cnt=4096.
//  6 Hold rsp_ready=0 for 5 cycles mid-response.
//    -> rsp_valid, ok and index stable; req_ready=0; no RAM writes.
//  7 rst_n=0 during an alloc scan -> rsp_valid=0 next edge, INIT re-runs.
//    First alloc after that returns idx 0.

Source files
------------

// File: rtl/bitmap_alloc_ctrl.sv
// rtl/bitmap_alloc_ctrl.sv - bitmap slot allocator owning a 1W/2R bitmap RAM
// Optional feature macro: BMA_USED_CNT_EN (used-slot counter, full-bitmap fast fail).
module bitmap_alloc_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64,
  localparam int BIT_W = $clog2(DATA_WIDTH),
  localparam int IDX_W = ADDR_WIDTH + BIT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [IDX_W-1:0]      req_index,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_ok,
  output logic [IDX_W-1:0]      rsp_index,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr1,
  input  logic [DATA_WIDTH-1:0] ram_read_data1,
  output logic [ADDR_WIDTH-1:0] ram_read_addr2,
  input  logic [DATA_WIDTH-1:0] ram_read_data2
`ifdef BMA_USED_CNT_EN
  ,
  output logic [IDX_W:0]        used_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CHK, S_RSP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] init_ptr, init_ptr_n;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_n;
  logic                  init_we_q, init_we_n;
  logic                  req_ready_q, req_ready_n;
  logic                  op_q, op_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [ADDR_WIDTH-1:0] hint, hint_n;
  logic [ADDR_WIDTH:0]   scanned, scanned_n, scanned_inc;
  logic                  ok_q, ok_n;
  logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_n;
  logic                  chk_we;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0] chk_data;
  logic                  accept;
  logic                  alloc_full;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [BIT_W-1:0]      req_bit;
  logic [BIT_W-1:0]      bit1, bit2;

  function automatic logic [BIT_W-1:0] lowest_zero(input logic [DATA_WIDTH-1:0] w);
    lowest_zero = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (!w[i]) lowest_zero = BIT_W'(i);
    end
  endfunction

  assign accept      = req_valid && req_ready_q;
  assign req_word    = idx_q[IDX_W-1:BIT_W];
  assign req_bit     = idx_q[BIT_W-1:0];
  assign bit1        = lowest_zero(ram_read_data1);
  assign bit2        = lowest_zero(ram_read_data2);
  assign scanned_inc = scanned + (ADDR_WIDTH + 1)'(2);

  always_comb begin
    state_n        = state;
    init_ptr_n     = '0;
    init_we_n      = 1'b0;
    init_addr_n    = '0;
    req_ready_n    = 1'b0;
    op_n           = op_q;
    idx_n          = idx_q;
    ptr_n          = ptr;
    hint_n         = hint;
    scanned_n      = scanned;
    ok_n           = ok_q;
    rsp_idx_n      = rsp_idx_q;
    ram_read_addr1 = '0;
    ram_read_addr2 = '0;
    chk_we         = 1'b0;
    chk_addr       = ptr;
    chk_data       = ram_read_data1;
    case (state)
      S_INIT: begin
        init_we_n   = 1'b1;
        init_addr_n = init_ptr;
        init_ptr_n  = init_ptr + ADDR_WIDTH'(1);
        if (init_ptr == ADDR_WIDTH'(DEPTH - 1)) state_n = S_IDLE;
      end
      S_IDLE: begin
        req_ready_n = !accept;
        if (accept) begin
          op_n      = req_op;
          idx_n     = req_index;
          ptr_n     = hint;
          scanned_n = '0;
          if (alloc_full) begin
            ok_n      = 1'b0;
            rsp_idx_n = '0;
            state_n   = S_RSP;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_RD: begin
        if (op_q) begin
          ram_read_addr1 = req_word;
        end else begin
          ram_read_addr1 = ptr;
          ram_read_addr2 = ptr + ADDR_WIDTH'(1);
        end
        state_n = S_CHK;
      end
      S_CHK: begin
        if (op_q) begin
          ok_n      = ram_read_data1[req_bit];
          rsp_idx_n = idx_q;
          state_n   = S_RSP;
          if (ram_read_data1[req_bit]) begin
            chk_we   = 1'b1;
            chk_addr = req_word;
            chk_data = ram_read_data1 & ~(DATA_WIDTH'(1) << req_bit);
          end
        end else if (~&ram_read_data1) begin
          chk_we    = 1'b1;
          chk_addr  = ptr;
          chk_data  = ram_read_data1 | (DATA_WIDTH'(1) << bit1);
          ok_n      = 1'b1;
          rsp_idx_n = {ptr, bit1};
          hint_n    = ptr;
          state_n   = S_RSP;
        end else if (~&ram_read_data2) begin
          chk_we    = 1'b1;
          chk_addr  = ptr + ADDR_WIDTH'(1);
          chk_data  = ram_read_data2 | (DATA_WIDTH'(1) << bit2);
          ok_n      = 1'b1;
          rsp_idx_n = {ptr + ADDR_WIDTH'(1), bit2};
          hint_n    = ptr + ADDR_WIDTH'(1);
          state_n   = S_RSP;
        end else begin
          // Both words full: advance one pair, reads for it go out this same cycle.
          ptr_n     = ptr + ADDR_WIDTH'(2);
          scanned_n = scanned_inc;
          if (scanned_inc >= (ADDR_WIDTH + 1)'(DEPTH)) begin
            ok_n      = 1'b0;
            rsp_idx_n = '0;
            state_n   = S_RSP;
          end else begin
            ram_read_addr1 = ptr + ADDR_WIDTH'(2);
            ram_read_addr2 = ptr + ADDR_WIDTH'(3);
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_ptr    <= '0;
      init_we_q   <= 1'b0;
      init_addr_q <= '0;
      req_ready_q <= 1'b0;
      op_q        <= 1'b0;
      idx_q       <= '0;
      ptr         <= '0;
      hint        <= '0;
      scanned     <= '0;
      ok_q        <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      state       <= state_n;
      init_ptr    <= init_ptr_n;
      init_we_q   <= init_we_n;
      init_addr_q <= init_addr_n;
      req_ready_q <= req_ready_n;
      op_q        <= op_n;
      idx_q       <= idx_n;
      ptr         <= ptr_n;
      hint        <= hint_n;
      scanned     <= scanned_n;
      ok_q        <= ok_n;
      rsp_idx_q   <= rsp_idx_n;
    end
  end

`ifdef BMA_USED_CNT_EN
  localparam logic [IDX_W:0] SLOTS = {1'b1, {IDX_W{1'b0}}};
  logic [IDX_W:0] used_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state == S_INIT) begin
      used_q <= '0;
    end else if (chk_we) begin
      used_q <= op_q ? used_q - (IDX_W + 1)'(1) : used_q + (IDX_W + 1)'(1);
    end
  end

  assign used_cnt   = used_q;
  assign alloc_full = !req_op && (used_q == SLOTS);
`else
  assign alloc_full = 1'b0;
`endif

  assign req_ready      = req_ready_q;
  assign rsp_valid      = (state == S_RSP);
  assign rsp_ok         = ok_q;
  assign rsp_index      = rsp_idx_q;
  // Init clears run from registers; allocation updates are issued straight from CHK.
  assign ram_write_en   = init_we_q | chk_we;
  assign ram_write_addr = chk_we ? chk_addr : init_addr_q;
  assign ram_write_data = chk_we ? chk_data : '0;

endmodule

// File: tb/tb_bitmap_alloc_ctrl.sv
// tb/tb_bitmap_alloc_ctrl.sv - scoreboard bench for bitmap_alloc_ctrl with a behavioural RAM
module tb_bitmap_alloc_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int IW    = 12;
  localparam int DEPTH = 64;
  localparam int TOTAL = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_op;
  logic [IW-1:0] req_index;
  logic          rsp_valid, rsp_ready, rsp_ok;
  logic [IW-1:0] rsp_index;
  logic          ram_write_en;
  logic [AW-1:0] ram_write_addr, ram_read_addr1, ram_read_addr2;
  logic [DW-1:0] ram_write_data, ram_read_data1, ram_read_data2;
`ifdef BMA_USED_CNT_EN
  logic [IW:0]   used_cnt;
`endif

  always #5 clk = ~clk;

  bitmap_alloc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok), .rsp_index(rsp_index),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_addr1(ram_read_addr1), .ram_read_data1(ram_read_data1),
    .ram_read_addr2(ram_read_addr2), .ram_read_data2(ram_read_data2)
`ifdef BMA_USED_CNT_EN
    , .used_cnt(used_cnt)
`endif
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
    ram_read_data1 <= mem[ram_read_addr1];
    ram_read_data2 <= mem[ram_read_addr2];
  end

  typedef struct {
    bit ok;
    int idx;
    int lat;
    int acc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_hint, ref_used;
  int            checks = 0, failures = 0;
  int            cyc = 0, first_seen = 0, wr_total = 0;
  bit            rsp_prev = 1'b0, in_init = 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int first_zero(input logic [DW-1:0] w);
    for (int b = 0; b < DW; b++) if (!w[b]) return b;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && !in_init && ram_write_en) wr_total++;
    if (rsp_valid && !rsp_prev) first_seen = cyc;
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        check_eq("rsp_unexpected", sbq.size(), 1);
      end else begin
        mon_e = sbq.pop_front();
        check_eq("rsp_ok", rsp_ok, mon_e.ok);
        check_eq("rsp_index", rsp_index, mon_e.idx);
        check_eq("rsp_latency", first_seen - mon_e.acc + 1, mon_e.lat);
      end
    end
    rsp_prev = rsp_valid;
  end

  task automatic do_reset_init();
    int good;
    in_init = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_wr_en_first", ram_write_en, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_ok", rsp_ok, 0);
    check_eq("rst_rsp_index", rsp_index, 0);
    check_eq("rst_wr_en", ram_write_en, 0);
    check_eq("rst_addrs", {ram_write_addr, ram_read_addr1, ram_read_addr2}, 0);
    rst_n = 1'b1;
    good = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (ram_write_en && ram_write_addr == AW'(i) && ram_write_data == '0) good++;
    end
    check_eq("init_writes", good, DEPTH);
    check_eq("init_ready_c64", req_ready, 0);
    @(negedge clk);
    check_eq("init_ready_c65", req_ready, 1);
    check_eq("init_wr_done", ram_write_en, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_hint = 0;
    ref_used = 0;
    sbq.delete();
    in_init = 1'b0;
  endtask

  // mode 0: complete normally, 1: stall rsp_ready for 5 cycles, 2: leave in flight
  task automatic send(input bit op, input int idx, input int mode);
    exp_t e;
    int   w, n, wr0, ww, b;
    bit   skip;
    skip = 1'b0;
`ifdef BMA_USED_CNT_EN
    skip = !op && (ref_used == TOTAL);
`endif
    w = 0;
    if (op) begin
      w     = idx / DW;
      e.ok  = ref_mem[w][idx % DW];
      e.idx = idx;
      e.lat = 3;
      if (e.ok) begin
        ref_mem[w][idx % DW] = 1'b0;
        ref_used--;
      end
    end else begin
      e.ok  = 1'b0;
      e.idx = 0;
      e.lat = skip ? 1 : 2 + DEPTH / 2;
      if (!skip) begin
        for (int k = 0; k < DEPTH; k++) begin
          ww = (ref_hint + k) % DEPTH;
          if (!e.ok && ref_mem[ww] != '1) begin
            b            = first_zero(ref_mem[ww]);
            e.ok         = 1'b1;
            e.idx        = ww * DW + b;
            e.lat        = 3 + k / 2;
            ref_hint     = ww;
            ref_mem[ww][b] = 1'b1;
            ref_used++;
            w            = ww;
          end
        end
      end
    end

    wr0 = wr_total;
    if (mode == 1) rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_index = IW'(idx);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      check_eq("req_accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mode == 2) return;

    if (mode == 1) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      for (int c = 0; c < 5; c++) begin
        if (c > 0) @(negedge clk);
        check_eq("hold_rsp_valid", rsp_valid, 1);
        check_eq("hold_rsp_ok", rsp_ok, e.ok);
        check_eq("hold_rsp_index", rsp_index, e.idx);
        check_eq("hold_req_ready", req_ready, 0);
        check_eq("hold_wr_en", ram_write_en, 0);
      end
      rsp_ready = 1'b1;
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_drained", sbq.size(), 0);
    @(negedge clk);
    check_eq("wr_count", wr_total - wr0, e.ok);
    check_eq("mem_word", mem[w], ref_mem[w]);
`ifdef BMA_USED_CNT_EN
    check_eq("used_cnt", used_cnt, ref_used);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_index = '0; rsp_ready = 1'b1;
    do_reset_init();

    repeat (3) send(1'b0, 0, 0);
    check_eq("t2_word0", mem[0], 64'h7);
    send(1'b1, 1, 0);
    check_eq("t3_free_word0", mem[0], 64'h5);
    send(1'b0, 0, 0);
    check_eq("t3_realloc_word0", mem[0], 64'h7);
    send(1'b1, 5, 0);
    for (int i = 0; i < 16; i++) send(1'($urandom_range(0, 1)), int'($urandom_range(0, 199)), 0);
    send(1'b0, 0, 1);

    do_reset_init();
    for (int i = 0; i < TOTAL; i++) send(1'b0, 0, 0);
`ifdef BMA_USED_CNT_EN
    check_eq("t5_used_full", used_cnt, TOTAL);
`endif
    check_eq("t5_word63", mem[63], 64'hFFFF_FFFF_FFFF_FFFF);
    send(1'b0, 0, 0);

    send(1'b1, 2048, 0);
    send(1'b0, 0, 2);
    repeat (5) @(posedge clk);
    do_reset_init();
    send(1'b0, 0, 0);
    check_eq("t7_word0", mem[0], 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
